// File: rtl/rv32i_types.sv
// Shared RV32I types and constants for the fetch stage.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  // addi x0, x0, 0
  localparam rv32i_word NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_perf_ctr.sv
// Fetch-stage performance counters: delivered instructions and HOLD cycles.
module if_perf_ctr
  import rv32i_types::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      fetch,
  input  logic      hold,
  output rv32i_word fetch_count,
  output rv32i_word stall_count
);

  // Free-running 32-bit counters, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch) fetch_count <= fetch_count + 32'd1;
      if (hold)  stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, talks to instruction memory via
// a read/resp handshake, buffers one word across IF/ID stalls and handles
// redirects, including those that land while a request is outstanding.
// Optional build macro IF_PERF_CNT_EN adds fetch_count / stall_count outputs.
module if_fetch_unit
  import rv32i_types::*;
#(
  parameter rv32i_word RESET_PC  = 32'h4000_0000,
  parameter rv32i_word NOP_INSTR = rv32i_types::NOP_INSTR
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      stall,
  input  logic      redirect,
  input  rv32i_word redirect_pc,
  output logic      imem_read,
  output rv32i_word imem_address,
  input  rv32i_word imem_rdata,
  input  logic      imem_resp,
  output logic      load_ifid,
  output rv32i_word instr_out,
  output rv32i_word pc_out
`ifdef IF_PERF_CNT_EN
  ,
  output rv32i_word fetch_count,
  output rv32i_word stall_count
`endif
);

  rv32i_word pc;
  rv32i_word req_addr;
  rv32i_word instr_buf;
  rv32i_word buf_pc;
  if_state_t state;

  rv32i_word target;
  rv32i_word seq_pc;

  // Redirect targets are word-aligned; masking keeps every redirect_pc bit in use.
  assign target       = redirect_pc & ~32'h3;
  assign seq_pc       = req_addr + 32'd4;
  assign imem_address = req_addr;

  // Handshake and IF/ID outputs decoded from current state and inputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    imem_read = 1'b0;
    load_ifid = 1'b0;
    instr_out = NOP_INSTR;
    pc_out    = '0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_read = 1'b1;
          if (imem_resp && !redirect && !stall) begin
            load_ifid = 1'b1;
            instr_out = imem_rdata;
            pc_out    = req_addr;
          end
        end
        HOLD: begin
          if (!redirect && !stall) begin
            load_ifid = 1'b1;
            instr_out = instr_buf;
            pc_out    = buf_pc;
          end
        end
        DISCARD: imem_read = 1'b1;
        default: ;
      endcase
    end
  end

  // FSM and fetch datapath; redirect outranks response and stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      instr_buf <= NOP_INSTR;
      buf_pc    <= '0;
      state     <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc <= target;
            if (imem_resp) req_addr <= target;   // data dropped, refetch now
            else           state    <= DISCARD;  // wait out the stale request
          end else if (imem_resp) begin
            pc <= seq_pc;
            if (stall) begin
              instr_buf <= imem_rdata;
              buf_pc    <= req_addr;
              state     <= HOLD;
            end else begin
              req_addr <= seq_pc;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc       <= target;
            req_addr <= target;
            state    <= FETCH;
          end else if (!stall) begin
            req_addr <= pc;
            state    <= FETCH;
          end
        end
        DISCARD: begin
          if (redirect) pc <= target;
          if (imem_resp) begin
            req_addr <= redirect ? target : pc;
            state    <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  if_perf_ctr u_perf_ctr (
    .clk         (clk),
    .rst         (rst),
    .fetch       (load_ifid),
    .hold        (state == HOLD),
    .fetch_count (fetch_count),
    .stall_count (stall_count)
  );
`else
  // Counters are not built; the fetch behaviour is unchanged.
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a memory model returning word=address
// with programmable latency, a stream-level reference model checked every
// cycle, and directed scenarios with hand-computed expectations.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        load_ifid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [31:0] fetch_base;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .load_ifid    (load_ifid),
    .instr_out    (instr_out),
    .pc_out       (pc_out)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .stall_count  (stall_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Memory model: accepts a read when idle, answers after 'lat' cycles with word=address.
  int          lat = 1;
  int          mem_cnt = 0;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = '0;

  assign imem_resp  = mem_busy && (mem_cnt == 0);
  assign imem_rdata = imem_resp ? mem_addr : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (rst) begin
      mem_busy <= 1'b0;
    end else if (mem_busy) begin
      if (mem_cnt == 0) mem_busy <= 1'b0;
      else              mem_cnt  <= mem_cnt - 1;
    end else if (imem_read) begin
      mem_busy <= 1'b1;
      mem_cnt  <= lat - 1;
      mem_addr <= imem_address;
    end
  end

  // Stream model: delivered instructions run sequentially from the last reset or
  // redirect target, never under stall or redirect; idle outputs are NOP / 0.
  logic [31:0] exp_pc = RESET_PC;

  always @(negedge clk) begin
    if (rst) begin
      check("m_rst_read", {31'd0, imem_read}, 32'd0);
      check("m_rst_load", {31'd0, load_ifid}, 32'd0);
      exp_pc = RESET_PC;
    end else begin
      if (mem_busy) begin
        check("m_read_held",   {31'd0, imem_read}, 32'd1);
        check("m_addr_stable", imem_address, mem_addr);
      end
      if (load_ifid) begin
        check("m_load_no_stall",    {31'd0, stall},    32'd0);
        check("m_load_no_redirect", {31'd0, redirect}, 32'd0);
        check("m_pc_seq",           pc_out,    exp_pc);
        check("m_instr_word",       instr_out, exp_pc);
        exp_pc = pc_out + 32'd4;
      end else begin
        check("m_idle_instr", instr_out, NOP);
        check("m_idle_pc",    pc_out,    32'd0);
      end
      if (redirect) exp_pc = redirect_pc & ~32'h3;
    end
  end

  // One cycle: drive inputs just after the edge, then settle before directed checks.
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = rp;
    #1;
  endtask

  task automatic expect_out(input string name, input logic rd, input logic [31:0] addr,
                            input logic ld, input logic [31:0] ins, input logic [31:0] pc);
    check({name, "_read"}, {31'd0, imem_read}, {31'd0, rd});
    if (rd) check({name, "_addr"}, imem_address, addr);
    check({name, "_load"},  {31'd0, load_ifid}, {31'd0, ld});
    check({name, "_instr"}, instr_out, ins);
    check({name, "_pc"},    pc_out,    pc);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    expect_out("rst", 0, 0, 0, NOP, 0);

    // 1-cycle memory: request, load, request
    step(0, 0, 0, 0); expect_out("t1_req0",  1, 32'h4000_0000, 0, NOP, 0);
    step(0, 0, 0, 0); expect_out("t1_load0", 1, 32'h4000_0000, 1, 32'h4000_0000, 32'h4000_0000);
    step(0, 0, 0, 0); expect_out("t1_req1",  1, 32'h4000_0004, 0, NOP, 0);

    // Stall held 5 cycles from the response for 0x40000004
    step(0, 1, 0, 0); expect_out("t2_resp_stalled", 1, 32'h4000_0004, 0, NOP, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0); expect_out("t2_hold", 0, 0, 0, NOP, 0);
    end
    step(0, 0, 0, 0); expect_out("t2_release", 0, 0, 1, 32'h4000_0004, 32'h4000_0004);
    lat = 3;
    step(0, 0, 0, 0); expect_out("t2_next_req", 1, 32'h4000_0008, 0, NOP, 0);
`ifdef IF_PERF_CNT_EN
    check("t2_fetch_count", fetch_count, 32'd2);
    check("t2_stall_count", stall_count, 32'd5);
`endif

    // Redirect while a 3-cycle request to 0x40000008 is pending
    step(0, 0, 1, 32'h4000_0100); expect_out("t3_redir",   1, 32'h4000_0008, 0, NOP, 0);
    step(0, 0, 0, 0);             expect_out("t3_discard", 1, 32'h4000_0008, 0, NOP, 0);
    step(0, 0, 0, 0);             expect_out("t3_drop",    1, 32'h4000_0008, 0, NOP, 0);
    step(0, 0, 0, 0);             expect_out("t3_new_req", 1, 32'h4000_0100, 0, NOP, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);             expect_out("t3_load", 1, 32'h4000_0100, 1, 32'h4000_0100, 32'h4000_0100);
    lat = 1;

    // Redirect in the same cycle as resp and stall
    step(0, 0, 0, 0);             expect_out("t4_req",   1, 32'h4000_0104, 0, NOP, 0);
    step(0, 1, 1, 32'h4000_0200); expect_out("t4_resp",  1, 32'h4000_0104, 0, NOP, 0);
    step(0, 1, 0, 0);             expect_out("t4_fetch", 1, 32'h4000_0200, 0, NOP, 0);

    // Reset while in HOLD
    step(0, 1, 0, 0); expect_out("t5_enter_hold", 1, 32'h4000_0200, 0, NOP, 0);
    step(1, 1, 0, 0); expect_out("t5_rst",        0, 0, 0, NOP, 0);
    step(0, 0, 0, 0); expect_out("t5_post_rst",   1, 32'h4000_0000, 0, NOP, 0);
    step(0, 0, 0, 0); expect_out("t5_load",       1, 32'h4000_0000, 1, 32'h4000_0000, 32'h4000_0000);

    // Redirect to the top of memory (low bits forced to 0), then wrap to 0
    step(0, 0, 1, 32'hFFFF_FFFF); expect_out("t6_redir", 1, 32'h4000_0004, 0, NOP, 0);
`ifdef IF_PERF_CNT_EN
    fetch_base = fetch_count;
`endif
    step(0, 0, 0, 0); expect_out("t6_drop",  1, 32'h4000_0004, 0, NOP, 0);
    step(0, 0, 0, 0); expect_out("t6_req0",  1, 32'hFFFF_FFFC, 0, NOP, 0);
    step(0, 0, 0, 0); expect_out("t6_load0", 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    step(0, 0, 0, 0); expect_out("t6_req1",  1, 32'h0000_0000, 0, NOP, 0);
    step(0, 0, 0, 0); expect_out("t6_load1", 1, 32'h0000_0000, 1, 32'h0000_0000, 32'h0000_0000);
    step(0, 0, 0, 0);
`ifdef IF_PERF_CNT_EN
    check("t6_fetch_count", fetch_count - fetch_base, 32'd2);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
